// File: rtl/vga_timing_gen.sv
//==============================================================================
// Module      : vga_timing_gen
// Description : 640x480@60 VGA raster timing (counters, blank, sync, markers).
//               Optional hs/vs delay pipeline enabled by VGA_SYNC_DELAY_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module vga_timing_gen #(
   parameter int H_VISIBLE  = 640,
   parameter int H_FRONT    = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BACK     = 48,
   parameter int V_VISIBLE  = 480,
   parameter int V_FRONT    = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BACK     = 33,
   parameter int SYNC_DELAY = 2
) (
   input  logic       vga_clk,
   input  logic       reset_n,
   output logic [9:0] DrawX,
   output logic [9:0] DrawY,
   output logic       blank,
   output logic       hs,
   output logic       vs,
   output logic       line_start,
   output logic       frame_start,
   output logic       vblank_start
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS_END  = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS_END  = 10'(V_VISIBLE);
   localparam logic [9:0] H_SYNC_BEG = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0] H_SYNC_END = 10'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [9:0] V_SYNC_BEG = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0] V_SYNC_END = 10'(V_VISIBLE + V_FRONT + V_SYNC);

   // Counters are 10 bits wide; reject timings that cannot be represented.
   if (H_TOTAL > 1024 || V_TOTAL > 1024 || SYNC_DELAY < 0) begin : g_param_check
      $error("vga_timing_gen: H_TOTAL/V_TOTAL must be <= 1024 and SYNC_DELAY >= 0");
   end

   logic [9:0] hc_q, hc_d;
   logic [9:0] vc_q, vc_d;
   logic       blank_q, blank_d;
   logic       hs_q, hs_d;
   logic       vs_q, vs_d;
   logic       line_start_q, line_start_d;
   logic       frame_start_q, frame_start_d;
   logic       vblank_start_q, vblank_start_d;

   // Decode from the next-state counters so flags line up with DrawX/DrawY.
   always_comb begin
      hc_d           = hc_q;
      vc_d           = vc_q;
      if (hc_q == H_LAST) begin
         hc_d = '0;
         if (vc_q == V_LAST) begin
            vc_d = '0;
         end else begin
            vc_d = vc_q + 10'd1;
         end
      end else begin
         hc_d = hc_q + 10'd1;
      end

      blank_d        = (hc_d < H_VIS_END) && (vc_d < V_VIS_END);
      hs_d           = !((hc_d >= H_SYNC_BEG) && (hc_d < H_SYNC_END));
      vs_d           = !((vc_d >= V_SYNC_BEG) && (vc_d < V_SYNC_END));
      line_start_d   = (hc_d == 10'd0);
      frame_start_d  = (hc_d == 10'd0) && (vc_d == 10'd0);
      vblank_start_d = (hc_d == 10'd0) && (vc_d == V_VIS_END);
   end

   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         hc_q           <= '0;
         vc_q           <= '0;
         blank_q        <= 1'b0;
         hs_q           <= 1'b1;
         vs_q           <= 1'b1;
         line_start_q   <= 1'b0;
         frame_start_q  <= 1'b0;
         vblank_start_q <= 1'b0;
      end else begin
         hc_q           <= hc_d;
         vc_q           <= vc_d;
         blank_q        <= blank_d;
         hs_q           <= hs_d;
         vs_q           <= vs_d;
         line_start_q   <= line_start_d;
         frame_start_q  <= frame_start_d;
         vblank_start_q <= vblank_start_d;
      end
   end

   assign DrawX        = hc_q;
   assign DrawY        = vc_q;
   assign blank        = blank_q;
   assign line_start   = line_start_q;
   assign frame_start  = frame_start_q;
   assign vblank_start = vblank_start_q;

`ifdef VGA_SYNC_DELAY_EN
   // Sync pins lag DrawX by SYNC_DELAY to match the downstream RGB pipeline.
   if (SYNC_DELAY == 0) begin : g_sync_pass
      assign hs = hs_q;
      assign vs = vs_q;
   end else begin : g_sync_pipe
      logic [SYNC_DELAY-1:0] hs_pipe_q, hs_pipe_d;
      logic [SYNC_DELAY-1:0] vs_pipe_q, vs_pipe_d;

      always_comb begin
         hs_pipe_d    = hs_pipe_q;
         vs_pipe_d    = vs_pipe_q;
         hs_pipe_d[0] = hs_q;
         vs_pipe_d[0] = vs_q;
         for (int i = 1; i < SYNC_DELAY; i++) begin
            hs_pipe_d[i] = hs_pipe_q[i-1];
            vs_pipe_d[i] = vs_pipe_q[i-1];
         end
      end

      always_ff @(posedge vga_clk or negedge reset_n) begin
         if (!reset_n) begin
            hs_pipe_q <= '1;
            vs_pipe_q <= '1;
         end else begin
            hs_pipe_q <= hs_pipe_d;
            vs_pipe_q <= vs_pipe_d;
         end
      end

      assign hs = hs_pipe_q[SYNC_DELAY-1];
      assign vs = vs_pipe_q[SYNC_DELAY-1];
   end
`else
   assign hs = hs_q;
   assign vs = vs_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
//==============================================================================
// Module      : tb_vga_timing_gen
// Description : Self-checking bench for vga_timing_gen on a scaled raster.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_vga_timing_gen;

   localparam int HV = 40, HF = 4, HS = 8, HB = 6;
   localparam int VV = 30, VF = 3, VS = 2, VB = 5;
   localparam int HT = HV + HF + HS + HB;
   localparam int VT = VV + VF + VS + VB;
   localparam int FR = HT * VT;
`ifdef VGA_SYNC_DELAY_EN
   localparam int D = 2;
`else
   localparam int D = 0;
`endif

   logic       vga_clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [9:0] DrawX, DrawY;
   logic       blank, hs, vs, line_start, frame_start, vblank_start;

   int total = 0;
   int bad   = 0;
   int n     = 0;
   int cnt_frame, cnt_line, cnt_vbl, cnt_blank, cnt_hs_low, cnt_vs_low;

   always #5 vga_clk = ~vga_clk;

   vga_timing_gen #(
      .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
      .SYNC_DELAY(2)
   ) dut (
      .vga_clk(vga_clk), .reset_n(reset_n),
      .DrawX(DrawX), .DrawY(DrawY), .blank(blank), .hs(hs), .vs(vs),
      .line_start(line_start), .frame_start(frame_start),
      .vblank_start(vblank_start)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Reference: the sample taken n edges after release shows raster position n mod FR.
   function automatic bit sync_hi_h(input int m);
      int hc;
      if (m <= 0) return 1'b1;
      hc = (m % FR) % HT;
      return !(hc >= HV + HF && hc < HV + HF + HS);
   endfunction

   function automatic bit sync_hi_v(input int m);
      int vc;
      if (m <= 0) return 1'b1;
      vc = (m % FR) / HT;
      return !(vc >= VV + VF && vc < VV + VF + VS);
   endfunction

   task automatic check_model();
      int p, hc, vc;
      bit first;
      p     = n % FR;
      hc    = p % HT;
      vc    = p / HT;
      first = (n == 0);
      chk($sformatf("DrawX n=%0d", n), 32'(DrawX), hc);
      chk($sformatf("DrawY n=%0d", n), 32'(DrawY), vc);
      chk($sformatf("blank n=%0d", n), 32'(blank), (!first && hc < HV && vc < VV) ? 1 : 0);
      chk($sformatf("hs n=%0d", n), 32'(hs), 32'(sync_hi_h(n - D)));
      chk($sformatf("vs n=%0d", n), 32'(vs), 32'(sync_hi_v(n - D)));
      chk($sformatf("line_start n=%0d", n), 32'(line_start), (!first && hc == 0) ? 1 : 0);
      chk($sformatf("frame_start n=%0d", n), 32'(frame_start), (!first && p == 0) ? 1 : 0);
      chk($sformatf("vblank_start n=%0d", n), 32'(vblank_start),
          (!first && hc == 0 && vc == VV) ? 1 : 0);
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, " DrawX"}, 32'(DrawX), 0);
      chk({tag, " DrawY"}, 32'(DrawY), 0);
      chk({tag, " blank"}, 32'(blank), 0);
      chk({tag, " hs"}, 32'(hs), 1);
      chk({tag, " vs"}, 32'(vs), 1);
      chk({tag, " markers"}, {29'd0, line_start, frame_start, vblank_start}, 0);
   endtask

   task automatic step(input int k);
      repeat (k) begin
         @(posedge vga_clk);
         n++;
         @(negedge vga_clk);
         check_model();
         cnt_frame  += int'(frame_start);
         cnt_line   += int'(line_start);
         cnt_vbl    += int'(vblank_start);
         cnt_blank  += int'(blank);
         cnt_hs_low += int'(!hs);
         cnt_vs_low += int'(!vs);
      end
   endtask

   // Assert reset between edges, confirm the immediate effect, hold, release.
   task automatic async_reset(input int sub, input int hold, input string tag);
      #(sub);
      reset_n = 1'b0;
      #1;
      check_reset_vals({tag, " async"});
      @(negedge vga_clk);
      repeat (hold) begin
         check_reset_vals({tag, " held"});
         @(negedge vga_clk);
      end
      reset_n = 1'b1;
      n = 0;
      check_model();
   endtask

   initial begin
      int target;
      reset_n = 1'b0;
      repeat (5) begin
         @(negedge vga_clk);
         check_reset_vals("reset");
      end
      reset_n = 1'b1;
      n = 0;
      check_model();

      step(1);
      chk("first edge DrawX", 32'(DrawX), 1);
      chk("first edge blank", 32'(blank), 1);

      cnt_frame = 0; cnt_line = 0; cnt_vbl = 0;
      cnt_blank = 0; cnt_hs_low = 0; cnt_vs_low = 0;
      step(FR);
      chk("frame frame_start count", cnt_frame, 1);
      chk("frame line_start count", cnt_line, VT);
      chk("frame vblank_start count", cnt_vbl, 1);
      chk("frame blank count", cnt_blank, HV * VV);
      chk("frame hs low count", cnt_hs_low, VT * HS);
      chk("frame vs low count", cnt_vs_low, HT * VS);

      // Land inside both sync pulses, then reset asynchronously.
      target = (VV + VF) * HT + HV + HF + 3;
      while ((n % FR) != target && n < 3 * FR) step(1);
      chk("pre-reset hs low", 32'(hs), 0);
      chk("pre-reset vs low", 32'(vs), 0);
      async_reset(2, 3, "mid-sync");
      step(HT + 5);

      for (int it = 0; it < 6; it++) begin
         step($urandom_range(50, 2 * FR));
         async_reset($urandom_range(1, 3), $urandom_range(1, 4), "random");
         step($urandom_range(1, 10));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
